// File: rtl/lsq_dep_checker.sv
// Two-stage, age-aware load/store dependence checker sitting between AGU and LSU.
// Optional feature macro: LSQ_PARTIAL_FWD_EN (partial store-to-load forwarding with o_fwd_mask).
module lsq_dep_checker #(
    parameter int WIDTH_SAQ  = 2,
    parameter int WIDTH_LAQ  = 2,
    parameter int WIDTH_ADDR = 32,
    parameter int WIDTH_REG  = 7,
    localparam int WIDTH_IDX = (WIDTH_SAQ > WIDTH_LAQ) ? WIDTH_SAQ : WIDTH_LAQ,
    localparam int WIDTH_PTR = WIDTH_IDX + 1,
    localparam int SIZE_SAQ  = 1 << WIDTH_SAQ,
    localparam int SIZE_LAQ  = 1 << WIDTH_LAQ
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             i_flush,
    input  logic                             i_req_valid,
    output logic                             o_req_ready,
    input  logic                             i_req_type,
    input  logic [WIDTH_ADDR-1:0]            i_req_addr,
    input  logic [3:0]                       i_req_mask,
    input  logic [WIDTH_REG-1:0]             i_req_rd,
    input  logic [WIDTH_PTR-1:0]             i_req_ptr,
    input  logic [WIDTH_SAQ:0]               i_saq_head,
    input  logic [WIDTH_LAQ:0]               i_laq_head,
    input  logic [SIZE_SAQ*(WIDTH_ADDR+7)-1:0] i_saq,
    input  logic [SIZE_LAQ*(WIDTH_ADDR+7)-1:0] i_laq,
    output logic                             o_res_valid,
    input  logic                             i_res_ready,
    output logic                             o_res_type,
    output logic [WIDTH_REG-1:0]             o_res_rd,
    output logic                             o_hit,
    output logic                             o_fwd,
    output logic                             o_stall,
`ifdef LSQ_PARTIAL_FWD_EN
    output logic [3:0]                       o_fwd_mask,
`endif
    output logic [WIDTH_IDX-1:0]             o_idx,
    output logic                             o_viol
);

    // Entry layout, MSB first: {val, aval, dval|exec, addr, mask}
    localparam int EW_SAQ     = WIDTH_ADDR + 7;
    localparam int EW_LAQ     = WIDTH_ADDR + 7;
    localparam int WIDTH_WORD = WIDTH_ADDR - 2;

    logic                   s1_v;
    logic                   s1_type;
    logic [WIDTH_WORD-1:0]  s1_word;
    logic [3:0]             s1_mask;
    logic [WIDTH_REG-1:0]   s1_rd;
    logic [WIDTH_PTR-1:0]   s1_ptr;
    logic                   s2_v;
    logic                   s1_adv;
    logic                   req_addr_unused;

    assign s1_adv          = ~s2_v | i_res_ready;
    assign o_req_ready     = i_flush | ~s1_v | s1_adv;
    assign o_res_valid     = s2_v;
    assign req_addr_unused = ^i_req_addr[1:0];

    logic [SIZE_SAQ-1:0] saq_match;
    logic [SIZE_SAQ-1:0] saq_dval;
    logic [3:0]          saq_emask [SIZE_SAQ];
    logic [SIZE_SAQ-1:0] saq_unused;
    logic [SIZE_LAQ-1:0] laq_viol;
    logic [SIZE_LAQ-1:0] laq_unused;

    for (genvar g = 0; g < SIZE_SAQ; g++) begin : g_saq
        logic [EW_SAQ-1:0] e;
        assign e             = i_saq[g*EW_SAQ +: EW_SAQ];
        assign saq_match[g]  = e[EW_SAQ-1] & e[EW_SAQ-2] &
                               (e[WIDTH_ADDR+3:6] == s1_word) & (|(e[3:0] & s1_mask));
        assign saq_dval[g]   = e[WIDTH_ADDR+4];
        assign saq_emask[g]  = e[3:0];
        assign saq_unused[g] = ^e[5:4];
    end

    for (genvar g = 0; g < SIZE_LAQ; g++) begin : g_laq
        logic [EW_LAQ-1:0] e;
        assign e             = i_laq[g*EW_LAQ +: EW_LAQ];
        assign laq_viol[g]   = e[EW_LAQ-1] & e[EW_LAQ-2] & e[WIDTH_ADDR+4] &
                               (e[WIDTH_ADDR+3:6] == s1_word) & (|(e[3:0] & s1_mask));
        assign laq_unused[g] = ^e[5:4];
    end

    // Entry index positions are relative to head; only the pointer carries a wrap bit,
    // so rel(ptr)==SIZE means the whole queue lies on the older side.
    logic [WIDTH_SAQ:0]   saq_ptr, saq_rel_ptr;
    logic [WIDTH_SAQ-1:0] saq_rel, ld_best, ld_idx;
    logic                 ld_hit, ld_dval;
    logic [3:0]           ld_mask;

    always_comb begin
        ld_hit      = 1'b0;
        ld_dval     = 1'b0;
        ld_idx      = '0;
        ld_best     = '0;
        ld_mask     = '0;
        saq_rel     = '0;
        saq_ptr     = {s1_ptr[WIDTH_PTR-1], s1_ptr[WIDTH_SAQ-1:0]};
        saq_rel_ptr = saq_ptr - i_saq_head;
        for (int i = 0; i < SIZE_SAQ; i++) begin
            saq_rel = WIDTH_SAQ'(i) - i_saq_head[WIDTH_SAQ-1:0];
            if (saq_match[i] && ({1'b0, saq_rel} < saq_rel_ptr) &&
                (!ld_hit || saq_rel > ld_best)) begin
                ld_hit  = 1'b1;
                ld_best = saq_rel;
                ld_idx  = WIDTH_SAQ'(i);
                ld_dval = saq_dval[i];
                ld_mask = saq_emask[i];
            end
        end
    end

    logic [WIDTH_LAQ:0]   laq_ptr, laq_rel_ptr;
    logic [WIDTH_LAQ-1:0] laq_rel, st_best, st_idx;
    logic                 st_viol;

    always_comb begin
        st_viol     = 1'b0;
        st_idx      = '0;
        st_best     = '0;
        laq_rel     = '0;
        laq_ptr     = {s1_ptr[WIDTH_PTR-1], s1_ptr[WIDTH_LAQ-1:0]};
        laq_rel_ptr = laq_ptr - i_laq_head;
        for (int j = 0; j < SIZE_LAQ; j++) begin
            laq_rel = WIDTH_LAQ'(j) - i_laq_head[WIDTH_LAQ-1:0];
            if (laq_viol[j] && ({1'b0, laq_rel} >= laq_rel_ptr) &&
                (!st_viol || laq_rel < st_best)) begin
                st_viol = 1'b1;
                st_best = laq_rel;
                st_idx  = WIDTH_LAQ'(j);
            end
        end
    end

    logic                 nxt_hit, nxt_fwd, nxt_stall, nxt_viol;
    logic [WIDTH_IDX-1:0] nxt_idx;
    logic [WIDTH_REG-1:0] nxt_rd;
    logic [3:0]           covered;
`ifdef LSQ_PARTIAL_FWD_EN
    logic [3:0]           nxt_fwd_mask;
`endif

    always_comb begin
        nxt_hit   = 1'b0;
        nxt_fwd   = 1'b0;
        nxt_stall = 1'b0;
        nxt_viol  = 1'b0;
        nxt_idx   = '0;
        nxt_rd    = '0;
        covered   = ld_mask & s1_mask;
`ifdef LSQ_PARTIAL_FWD_EN
        nxt_fwd_mask = '0;
`endif
        if (s1_type) begin
            nxt_viol = st_viol;
            nxt_idx  = WIDTH_IDX'(st_idx);
        end else begin
            nxt_hit = ld_hit;
            nxt_rd  = s1_rd;
            nxt_idx = WIDTH_IDX'(ld_idx);
`ifdef LSQ_PARTIAL_FWD_EN
            nxt_fwd      = ld_hit & ld_dval;
            nxt_fwd_mask = nxt_fwd ? covered : 4'h0;
`else
            nxt_fwd      = ld_hit & ld_dval & (covered == s1_mask);
`endif
            nxt_stall = ld_hit & ~nxt_fwd;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v       <= 1'b0;
            s1_type    <= 1'b0;
            s1_word    <= '0;
            s1_mask    <= '0;
            s1_rd      <= '0;
            s1_ptr     <= '0;
            s2_v       <= 1'b0;
            o_res_type <= 1'b0;
            o_res_rd   <= '0;
            o_hit      <= 1'b0;
            o_fwd      <= 1'b0;
            o_stall    <= 1'b0;
            o_idx      <= '0;
            o_viol     <= 1'b0;
`ifdef LSQ_PARTIAL_FWD_EN
            o_fwd_mask <= '0;
`endif
        end else if (i_flush) begin
            s1_v <= 1'b0;
            s2_v <= 1'b0;
        end else begin
            if (s1_adv) begin
                s2_v <= s1_v;
                if (s1_v) begin
                    o_res_type <= s1_type;
                    o_res_rd   <= nxt_rd;
                    o_hit      <= nxt_hit;
                    o_fwd      <= nxt_fwd;
                    o_stall    <= nxt_stall;
                    o_idx      <= nxt_idx;
                    o_viol     <= nxt_viol;
`ifdef LSQ_PARTIAL_FWD_EN
                    o_fwd_mask <= nxt_fwd_mask;
`endif
                end
            end
            if (o_req_ready) begin
                s1_v <= i_req_valid;
                if (i_req_valid) begin
                    s1_type <= i_req_type;
                    s1_word <= i_req_addr[WIDTH_ADDR-1:2];
                    s1_mask <= i_req_mask;
                    s1_rd   <= i_req_rd;
                    s1_ptr  <= i_req_ptr;
                end
            end
        end
    end

endmodule

// File: tb/tb_lsq_dep_checker.sv
// Directed bench for lsq_dep_checker with hand-computed expectations.
module tb_lsq_dep_checker;
    localparam int EW = 39;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          i_flush = 1'b0;
    logic          i_req_valid = 1'b0;
    logic          o_req_ready;
    logic          i_req_type = 1'b0;
    logic [31:0]   i_req_addr = '0;
    logic [3:0]    i_req_mask = '0;
    logic [6:0]    i_req_rd = '0;
    logic [2:0]    i_req_ptr = '0;
    logic [2:0]    i_saq_head = '0;
    logic [2:0]    i_laq_head = '0;
    logic [4*EW-1:0] i_saq = '0;
    logic [4*EW-1:0] i_laq = '0;
    logic          o_res_valid;
    logic          i_res_ready = 1'b1;
    logic          o_res_type;
    logic [6:0]    o_res_rd;
    logic          o_hit, o_fwd, o_stall, o_viol;
    logic [1:0]    o_idx;
`ifdef LSQ_PARTIAL_FWD_EN
    logic [3:0]    o_fwd_mask;
`endif

    int total = 0;
    int bad = 0;

    lsq_dep_checker dut (
        .clk(clk), .rst_n(rst_n), .i_flush(i_flush),
        .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
        .i_req_type(i_req_type), .i_req_addr(i_req_addr), .i_req_mask(i_req_mask),
        .i_req_rd(i_req_rd), .i_req_ptr(i_req_ptr),
        .i_saq_head(i_saq_head), .i_laq_head(i_laq_head),
        .i_saq(i_saq), .i_laq(i_laq),
        .o_res_valid(o_res_valid), .i_res_ready(i_res_ready),
        .o_res_type(o_res_type), .o_res_rd(o_res_rd),
        .o_hit(o_hit), .o_fwd(o_fwd), .o_stall(o_stall),
`ifdef LSQ_PARTIAL_FWD_EN
        .o_fwd_mask(o_fwd_mask),
`endif
        .o_idx(o_idx), .o_viol(o_viol)
    );

    always #5 clk = ~clk;

    function automatic logic [EW-1:0] ent(input logic v, input logic a, input logic d,
                                          input logic [31:0] addr, input logic [3:0] m);
        return {v, a, d, addr, m};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Presents one request, waits for acceptance plus one stage; result is then visible.
    task automatic issue(input logic t, input logic [31:0] a, input logic [3:0] m,
                         input logic [6:0] rd, input logic [2:0] p);
        i_req_type  = t;
        i_req_addr  = a;
        i_req_mask  = m;
        i_req_rd    = rd;
        i_req_ptr   = p;
        i_req_valid = 1'b1;
        step();
        i_req_valid = 1'b0;
        chk("latency_not_yet", o_res_valid, 0);
        step();
        chk("latency_valid", o_res_valid, 1);
    endtask

    initial begin
        #2;
        chk("rst_valid", o_res_valid, 0);
        chk("rst_hit", o_hit, 0);
        chk("rst_idx", o_idx, 0);
        chk("rst_viol", o_viol, 0);
        #10 rst_n = 1'b1;
        step();
        chk("rst_ready", o_req_ready, 1);

        // single older full-cover store
        i_saq[1*EW +: EW] = ent(1, 1, 1, 32'h100, 4'hF);
        i_saq_head = 3'd0;
        issue(0, 32'h100, 4'hF, 7'd5, 3'd3);
        chk("t1_hit", o_hit, 1);
        chk("t1_fwd", o_fwd, 1);
        chk("t1_stall", o_stall, 0);
        chk("t1_idx", o_idx, 1);
        chk("t1_rd", o_res_rd, 5);
        chk("t1_type", o_res_type, 0);
        chk("t1_viol", o_viol, 0);

        // different word, same low bits
        issue(0, 32'h104, 4'hF, 7'd5, 3'd3);
        chk("word_miss_hit", o_hit, 0);
        chk("word_miss_idx", o_idx, 0);

        // youngest-older selection
        i_saq = '0;
        i_saq[0*EW +: EW] = ent(1, 1, 1, 32'h100, 4'hF);
        i_saq[2*EW +: EW] = ent(1, 1, 1, 32'h100, 4'hF);
        issue(0, 32'h100, 4'hF, 7'd6, 3'd3);
        chk("age_p3_idx", o_idx, 2);
        chk("age_p3_hit", o_hit, 1);
        issue(0, 32'h100, 4'hF, 7'd6, 3'd1);
        chk("age_p1_idx", o_idx, 0);
        chk("age_p1_hit", o_hit, 1);
        issue(0, 32'h100, 4'hF, 7'd6, 3'd0);
        chk("age_empty_hit", o_hit, 0);
        issue(0, 32'h100, 4'hF, 7'd6, 3'b100);
        chk("age_full_idx", o_idx, 2);

        // wrapped SAQ: head=3 wrap0, ptr=1 wrap1 -> older order 3,0
        i_saq = '0;
        i_saq[0*EW +: EW] = ent(1, 1, 1, 32'h100, 4'hF);
        i_saq[3*EW +: EW] = ent(1, 1, 1, 32'h100, 4'hF);
        i_saq_head = 3'b011;
        issue(0, 32'h100, 4'h1, 7'd7, 3'b101);
        chk("wrap_idx", o_idx, 0);
        chk("wrap_hit", o_hit, 1);
        i_saq = '0;
        i_saq[1*EW +: EW] = ent(1, 1, 1, 32'h100, 4'hF);
        issue(0, 32'h100, 4'h1, 7'd7, 3'b101);
        chk("wrap_young_hit", o_hit, 0);

        // store violation search
        i_saq = '0;
        i_saq_head = 3'd0;
        i_laq[2*EW +: EW] = ent(1, 1, 1, 32'h200, 4'b0010);
        i_laq[3*EW +: EW] = ent(1, 1, 1, 32'h200, 4'b1100);
        i_laq_head = 3'd0;
        issue(1, 32'h200, 4'b0011, 7'd9, 3'd2);
        chk("st_viol", o_viol, 1);
        chk("st_idx", o_idx, 2);
        chk("st_hit", o_hit, 0);
        chk("st_type", o_res_type, 1);
        issue(1, 32'h200, 4'b0011, 7'd9, 3'd3);
        chk("st_older_viol", o_viol, 0);
        i_laq[2*EW +: EW] = ent(1, 1, 0, 32'h200, 4'b0010);
        issue(1, 32'h200, 4'b0011, 7'd9, 3'd2);
        chk("st_noexec_viol", o_viol, 0);
        i_laq = '0;

        // partial coverage and data-not-ready
        i_saq[1*EW +: EW] = ent(1, 1, 1, 32'h100, 4'b0011);
        issue(0, 32'h100, 4'hF, 7'd3, 3'd3);
        chk("part_hit", o_hit, 1);
        chk("part_idx", o_idx, 1);
`ifdef LSQ_PARTIAL_FWD_EN
        chk("part_fwd", o_fwd, 1);
        chk("part_stall", o_stall, 0);
        chk("part_mask", o_fwd_mask, 4'b0011);
`else
        chk("part_fwd", o_fwd, 0);
        chk("part_stall", o_stall, 1);
`endif
        i_saq[1*EW +: EW] = ent(1, 1, 0, 32'h100, 4'hF);
        issue(0, 32'h100, 4'hF, 7'd3, 3'd3);
        chk("nodata_fwd", o_fwd, 0);
        chk("nodata_stall", o_stall, 1);

        // back-to-back with backpressure
        i_saq = '0;
        i_saq[0*EW +: EW] = ent(1, 1, 1, 32'h100, 4'hF);
        i_saq[1*EW +: EW] = ent(1, 1, 1, 32'h200, 4'hF);
        i_req_type = 0; i_req_mask = 4'hF; i_req_ptr = 3'd3; i_res_ready = 1'b1;
        i_req_valid = 1'b1; i_req_addr = 32'h100; i_req_rd = 7'd1;
        step();
        i_req_addr = 32'h200; i_req_rd = 7'd2;
        step();
        i_res_ready = 1'b0; i_req_addr = 32'h300; i_req_rd = 7'd3;
        #1;
        chk("bp_ready_low", o_req_ready, 0);
        chk("bp_a_valid", o_res_valid, 1);
        chk("bp_a_rd", o_res_rd, 1);
        step();
        chk("bp_hold1_rd", o_res_rd, 1);
        chk("bp_hold1_idx", o_idx, 0);
        chk("bp_hold1_ready", o_req_ready, 0);
        step();
        chk("bp_hold2_rd", o_res_rd, 1);
        chk("bp_hold2_hit", o_hit, 1);
        i_res_ready = 1'b1;
        step();
        i_req_valid = 1'b0;
        chk("bp_b_valid", o_res_valid, 1);
        chk("bp_b_rd", o_res_rd, 2);
        chk("bp_b_idx", o_idx, 1);
        step();
        chk("bp_c_valid", o_res_valid, 1);
        chk("bp_c_rd", o_res_rd, 3);
        chk("bp_c_hit", o_hit, 0);
        step();
        chk("bp_drain", o_res_valid, 0);

        // flush with results in both stages
        i_req_valid = 1'b1; i_req_addr = 32'h100; i_req_rd = 7'd4;
        step();
        i_req_rd = 7'd8;
        step();
        i_req_valid = 1'b0;
        chk("fl_pre_valid", o_res_valid, 1);
        i_flush = 1'b1;
        step();
        i_flush = 1'b0;
        chk("fl_valid0", o_res_valid, 0);
        chk("fl_ready", o_req_ready, 1);
        step();
        chk("fl_valid1", o_res_valid, 0);

        // accept in the flush cycle is dropped
        i_flush = 1'b1; i_req_valid = 1'b1;
        step();
        i_flush = 1'b0; i_req_valid = 1'b0;
        step();
        chk("fl_same_valid0", o_res_valid, 0);
        step();
        chk("fl_same_valid1", o_res_valid, 0);

        // reset mid-operation
        i_req_valid = 1'b1;
        step();
        i_req_valid = 1'b0;
        rst_n = 1'b0;
        #2 rst_n = 1'b1;
        chk("rst_mid_valid0", o_res_valid, 0);
        step();
        chk("rst_mid_valid1", o_res_valid, 0);
        step();
        chk("rst_mid_valid2", o_res_valid, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
